div_share_ctrl: RTL and testbench

- Sequencer/arbiter that shares one fixed-latency `div` datapath (8-bit A/B operands, 8-bit quotient) among N_REQ requesters in the CORDIC neuron accelerator.
- Arbitrates requesters round-robin and holds the winner's operands stable on the divider for DIV_LAT cycles.
- Captures the quotient and returns it with the requester ID over a valid/ready response port.
- Flags divide-by-zero without using the divider.

---
 rtl/div_share_ctrl.sv | 153 +++++++++++++++
 tb/tb_div_share_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one fixed-latency divider among N_REQ requesters.
// Requests are arbitrated round-robin. The winner's operands are held on the
// divider for DIV_LAT cycles. The quotient is returned with the requester ID
// over a valid/ready port. Divide-by-zero is answered directly with 8'hFF and
// an error flag, and the divider is not used for it.
module div_share_ctrl #(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int DIV_LAT = 8,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    output logic [W-1:0]         div_a,
    output logic [W-1:0]         div_b,
    output logic                 div_start,
    input  logic [W-1:0]         div_q,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [W-1:0]         rsp_q,
    output logic                 rsp_err
);

    localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_r;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [CNT_W-1:0]    cnt_r;

    logic [ID_W:0]       pick_s;
    logic                grant_vld_s;
    logic [ID_W-1:0]     grant_id_s;
    logic [W-1:0]        sel_a_s;
    logic [W-1:0]        sel_b_s;

    // Round-robin search: returns {found, index} of the first valid requester
    // starting at ptr. Iterating from the far end lets the nearest hit win.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                              input logic [ID_W-1:0]  ptr);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] idx;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(ptr) + k) % N_REQ);
            if (valid[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign grant_vld_s = pick_s[ID_W];
    assign grant_id_s  = pick_s[ID_W-1:0];
    assign sel_a_s     = req_a[int'(grant_id_s)*W +: W];
    assign sel_b_s     = req_b[int'(grant_id_s)*W +: W];

    // Arbitration and accept strobe; only offered in IDLE and never under reset.
    always_comb begin
        pick_s    = rr_pick(req_valid, rr_ptr_r);
        req_ready = '0;
        if (rst_n && (state_r == IDLE) && pick_s[ID_W]) begin
            req_ready = N_REQ'(1) << pick_s[ID_W-1:0];
        end else begin
            req_ready = '0;
        end
    end

    // Sequencer: accept, run the divider for DIV_LAT cycles, then hold the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            rr_ptr_r  <= '0;
            cnt_r     <= '0;
            div_a     <= '0;
            div_b     <= '0;
            div_start <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_q     <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    div_start <= 1'b0;
                    rsp_valid <= 1'b0;
                    if (grant_vld_s) begin
                        rsp_id   <= grant_id_s;
                        rr_ptr_r <= ID_W'((int'(grant_id_s) + 1) % N_REQ);
                        if (sel_b_s == {W{1'b0}}) begin
                            // Answer divide-by-zero locally; divider inputs stay put.
                            rsp_q     <= {W{1'b1}};
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state_r   <= RESP;
                        end else begin
                            div_a     <= sel_a_s;
                            div_b     <= sel_b_s;
                            div_start <= 1'b1;
                            rsp_err   <= 1'b0;
                            cnt_r     <= '0;
                            state_r   <= BUSY;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    div_start <= 1'b0;
                    if (cnt_r == CNT_LAST) begin
                        rsp_q     <= div_q;
                        rsp_valid <= 1'b1;
                        cnt_r     <= '0;
                        state_r   <= RESP;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                        state_r <= BUSY;
                    end
                end
                RESP: begin
                    div_start <= 1'b0;
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        rsp_valid <= 1'b1;
                        state_r   <= RESP;
                    end
                end
                default: begin
                    div_start <= 1'b0;
                    rsp_valid <= 1'b0;
                    cnt_r     <= '0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed self-checking bench for div_share_ctrl with a behavioural divider
// that returns floor(A*256/B) DIV_LAT cycles after div_start.
module tb_div_share_ctrl;

    localparam int N_REQ   = 4;
    localparam int W       = 8;
    localparam int DIV_LAT = 8;
    localparam int ID_W    = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*W-1:0]  req_a;
    logic [N_REQ*W-1:0]  req_b;
    logic [W-1:0]        div_a;
    logic [W-1:0]        div_b;
    logic                div_start;
    logic [W-1:0]        div_q = 8'h00;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [W-1:0]        rsp_q;
    logic                rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    int          dm_cnt = 0;
    logic [W-1:0] dm_res = 8'h00;

    div_share_ctrl #(
        .N_REQ(N_REQ), .W(W), .DIV_LAT(DIV_LAT), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .div_a(div_a), .div_b(div_b), .div_start(div_start), .div_q(div_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_err(rsp_err)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Divider model: garbage right after start, real quotient valid before edge start+DIV_LAT.
    always @(posedge clk) begin
        if (div_start) begin
            dm_cnt <= 1;
            div_q  <= 8'h5A;
            dm_res <= 8'(16'({div_a, 8'h00}) / 16'({8'h00, div_b}));
        end else if (dm_cnt == DIV_LAT - 2) begin
            div_q  <= dm_res;
            dm_cnt <= 0;
        end else if (dm_cnt != 0) begin
            dm_cnt <= dm_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
    endtask

    // One full normal operation starting in IDLE with the request already pending.
    task automatic op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] q, input logic [3:0] drop_mask,
                      input logic [3:0] late_mask, input bit hold);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        #1;
        chk("grant", 32'(req_ready), 32'(oh));
        tick();
        req_valid = req_valid & ~drop_mask;
        #1;
        chk("start_pulse", 32'(div_start), 32'd1);
        chk("div_a", 32'(div_a), 32'(a));
        chk("div_b", 32'(div_b), 32'(b));
        chk("busy_ready", 32'(req_ready), 32'd0);
        chk("busy_valid", 32'(rsp_valid), 32'd0);
        for (int k = 1; k < DIV_LAT; k++) begin
            tick();
            if (k == 3) begin
                req_valid = req_valid | late_mask;
                #1;
            end
            chk("start_low", 32'(div_start), 32'd0);
            chk("div_a_hold", 32'(div_a), 32'(a));
            chk("div_b_hold", 32'(div_b), 32'(b));
            chk("busy_ready", 32'(req_ready), 32'd0);
            chk("busy_valid", 32'(rsp_valid), 32'd0);
        end
        tick();
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(id));
        chk("rsp_q", 32'(rsp_q), 32'(q));
        chk("rsp_err", 32'(rsp_err), 32'd0);
        chk("resp_ready", 32'(req_ready), 32'd0);
        if (!hold) begin
            tick();
            chk("rsp_drop", 32'(rsp_valid), 32'd0);
        end
    endtask

    // Directed sequence.
    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_div_start", 32'(div_start), 32'd0);
        chk("rst_div_a", 32'(div_a), 32'd0);
        chk("rst_rsp_q", 32'(rsp_q), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Round-robin with every requester asserting.
        set_ops(0, 8'd10, 8'd20);
        set_ops(1, 8'd15, 8'd60);
        set_ops(2, 8'd1,  8'd3);
        set_ops(3, 8'd3,  8'd7);
        req_valid = 4'b1111;
        op(0, 8'd10, 8'd20, 8'h80, 4'b0000, 4'b0000, 1'b0);
        op(1, 8'd15, 8'd60, 8'h40, 4'b0000, 4'b0000, 1'b0);
        op(2, 8'd1,  8'd3,  8'h55, 4'b0000, 4'b0000, 1'b0);
        op(3, 8'd3,  8'd7,  8'h6D, 4'b0000, 4'b0000, 1'b0);
        op(0, 8'd10, 8'd20, 8'h80, 4'b0000, 4'b0000, 1'b0);
        op(1, 8'd15, 8'd60, 8'h40, 4'b1111, 4'b0000, 1'b0);

        // Divide-by-zero from requester 2.
        set_ops(2, 8'd5, 8'd0);
        req_valid = 4'b0100;
        #1;
        chk("dbz_grant", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        chk("dbz_valid", 32'(rsp_valid), 32'd1);
        chk("dbz_q", 32'(rsp_q), 32'hFF);
        chk("dbz_err", 32'(rsp_err), 32'd1);
        chk("dbz_id", 32'(rsp_id), 32'd2);
        chk("dbz_no_start", 32'(div_start), 32'd0);
        chk("dbz_div_a_kept", 32'(div_a), 32'd15);
        chk("dbz_div_b_kept", 32'(div_b), 32'd60);
        tick();
        chk("dbz_drop", 32'(rsp_valid), 32'd0);
        chk("dbz_no_start2", 32'(div_start), 32'd0);

        // Pointer now 3: req0 beats req2; req3 arrives late during BUSY.
        set_ops(0, 8'd7, 8'd49);
        set_ops(2, 8'd1, 8'd3);
        set_ops(3, 8'd9, 8'd200);
        req_valid = 4'b0101;
        op(0, 8'd7, 8'd49, 8'h24, 4'b0101, 4'b1000, 1'b0);
        op(3, 8'd9, 8'd200, 8'h0B, 4'b1000, 4'b0000, 1'b0);

        // Backpressure with req1 pending.
        set_ops(0, 8'd1, 8'd4);
        set_ops(1, 8'd3, 8'd10);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        op(0, 8'd1, 8'd4, 8'h40, 4'b0001, 4'b0010, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_q", 32'(rsp_q), 32'h40);
            chk("bp_id", 32'(rsp_id), 32'd0);
            chk("bp_err", 32'(rsp_err), 32'd0);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_drop", 32'(rsp_valid), 32'd0);
        op(1, 8'd3, 8'd10, 8'h4C, 4'b0010, 4'b0000, 1'b0);

        // Reset three cycles into BUSY of req3; req1 joins before reset.
        set_ops(3, 8'd2, 8'd3);
        req_valid = 4'b1000;
        #1;
        chk("rb_grant", 32'(req_ready), 32'h8);
        tick();
        chk("rb_start", 32'(div_start), 32'd1);
        tick();
        tick();
        tick();
        req_valid = 4'b1010;
        rst_n = 1'b0;
        #1;
        chk("rb_valid", 32'(rsp_valid), 32'd0);
        chk("rb_start0", 32'(div_start), 32'd0);
        chk("rb_ready", 32'(req_ready), 32'd0);
        chk("rb_div_a", 32'(div_a), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rb_hold_valid", 32'(rsp_valid), 32'd0);
            chk("rb_hold_ready", 32'(req_ready), 32'd0);
        end
        rst_n = 1'b1;
        op(1, 8'd3, 8'd10, 8'h4C, 4'b0010, 4'b0000, 1'b0);
        op(3, 8'd2, 8'd3, 8'hAA, 4'b1000, 4'b0000, 1'b0);
        tick();
        chk("end_valid", 32'(rsp_valid), 32'd0);
        chk("end_ready", 32'(req_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
